// File: rtl/mem_port_arbiter.sv
// Arbiter that shares one single-port memory between instruction fetch and the
// load/store path, one req/gnt/rvalid transaction at a time, with bounded fetch starvation.
module mem_port_arbiter #(
  parameter int unsigned STARVE_MAX = 4,
  parameter int unsigned TIMEOUT    = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        IReqF,
  input  logic [31:0] IAddrF,
  output logic [31:0] IRdataF,
  output logic        IValidF,
  input  logic        DReqM,
  input  logic        DWeM,
  input  logic [31:0] DAddrM,
  input  logic [31:0] DWdataM,
  input  logic [3:0]  DByteEnM,
  output logic [31:0] DRdataM,
  output logic        DValidM,
  output logic        StallF,
  output logic        StallM,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        BusErr
);

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);
  localparam logic [7:0] TMO_LAST   = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_RESP = 2'd3
  } state_t;

  state_t      state_r, state_nxt_s;
  logic        owner_fetch_r;
  logic        we_r;
  logic [31:0] addr_r, wdata_r;
  logic [3:0]  be_r;
  logic [3:0]  starve_r, starve_nxt_s;
  logic [7:0]  tmo_r, tmo_nxt_s;
  logic [31:0] irdata_r, drdata_r;
  logic        ivalid_r, dvalid_r, buserr_r;

  logic        latch_s, grant_fetch_s, capture_s, timeout_s, enter_resp_s;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state, arbitration and counter update decisions
  always_comb begin
    state_nxt_s   = state_r;
    latch_s       = 1'b0;
    grant_fetch_s = 1'b0;
    capture_s     = 1'b0;
    timeout_s     = 1'b0;
    enter_resp_s  = 1'b0;
    starve_nxt_s  = starve_r;
    tmo_nxt_s     = 8'd0;
    case (state_r)
      ST_IDLE: begin
        if (IReqF || DReqM) begin
          latch_s       = 1'b1;
          state_nxt_s   = ST_REQ;
          // data has priority unless fetch has already lost STARVE_MAX times in a row
          grant_fetch_s = IReqF && (!DReqM || (starve_r == STARVE_LIM));
          if (grant_fetch_s) begin
            starve_nxt_s = 4'd0;
          end else if (IReqF) begin
            starve_nxt_s = (starve_r == STARVE_LIM) ? starve_r : starve_r + 4'd1;
          end else begin
            starve_nxt_s = 4'd0;
          end
        end else begin
          starve_nxt_s = 4'd0;
        end
      end
      ST_REQ: begin
        if (mem_gnt) begin
          if (we_r) begin
            state_nxt_s  = ST_RESP;
            enter_resp_s = 1'b1;
          end else begin
            state_nxt_s = ST_WAIT;
          end
        end else begin
          state_nxt_s = ST_REQ;
        end
      end
      ST_WAIT: begin
        if (mem_rvalid) begin
          capture_s    = 1'b1;
          enter_resp_s = 1'b1;
          state_nxt_s  = ST_RESP;
        end else if (tmo_r == TMO_LAST) begin
          timeout_s    = 1'b1;
          enter_resp_s = 1'b1;
          state_nxt_s  = ST_RESP;
        end else begin
          tmo_nxt_s = tmo_r + 8'd1;
        end
      end
      ST_RESP: begin
        state_nxt_s = ST_IDLE;
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Latched transaction fields plus starvation and timeout counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_fetch_r <= 1'b0;
      we_r          <= 1'b0;
      addr_r        <= 32'h0;
      wdata_r       <= 32'h0;
      be_r          <= 4'h0;
      starve_r      <= 4'd0;
      tmo_r         <= 8'd0;
    end else begin
      starve_r <= starve_nxt_s;
      tmo_r    <= tmo_nxt_s;
      if (latch_s) begin
        owner_fetch_r <= grant_fetch_s;
        if (grant_fetch_s) begin
          we_r    <= 1'b0;
          addr_r  <= IAddrF;
          wdata_r <= 32'h0;
          be_r    <= 4'hF;
        end else begin
          we_r    <= DWeM;
          addr_r  <= DAddrM;
          wdata_r <= DWdataM;
          be_r    <= DByteEnM;
        end
      end
    end
  end

  // Completion pulses and per-requester read data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ivalid_r <= 1'b0;
      dvalid_r <= 1'b0;
      buserr_r <= 1'b0;
      irdata_r <= 32'h0;
      drdata_r <= 32'h0;
    end else begin
      ivalid_r <= enter_resp_s & owner_fetch_r;
      dvalid_r <= enter_resp_s & ~owner_fetch_r;
      buserr_r <= timeout_s;
      if (capture_s || timeout_s) begin
        if (owner_fetch_r) begin
          irdata_r <= capture_s ? mem_rdata : 32'h0;
        end else begin
          drdata_r <= capture_s ? mem_rdata : 32'h0;
        end
      end
    end
  end

  assign mem_req   = (state_r == ST_REQ);
  assign mem_we    = (state_r == ST_REQ) & we_r;
  assign mem_addr  = addr_r;
  assign mem_wdata = wdata_r;
  assign mem_be    = be_r;

  assign IRdataF = irdata_r;
  assign IValidF = ivalid_r;
  assign DRdataM = drdata_r;
  assign DValidM = dvalid_r;
  assign BusErr  = buserr_r;

  // rst_n gating keeps the stalls low while the core is held in reset
  assign StallF = rst_n & IReqF & ~ivalid_r;
  assign StallM = rst_n & DReqM & ~dvalid_r;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: scoreboard of expected completions,
// checked with immediate assertions whenever a Valid pulse appears.
module tb_mem_port_arbiter;

  logic        clk, rst_n;
  logic        IReqF, DReqM, DWeM;
  logic [31:0] IAddrF, DAddrM, DWdataM;
  logic [3:0]  DByteEnM;
  logic [31:0] IRdataF, DRdataM, mem_addr, mem_wdata;
  logic        IValidF, DValidM, StallF, StallM, mem_req, mem_we, BusErr;
  logic [3:0]  mem_be;

  logic        auto_mem, man_gnt, man_rvalid;
  logic [31:0] man_rdata;
  logic        auto_gnt, auto_rvalid;
  logic [31:0] auto_rdata;
  logic        gnt_s, rvalid_s;
  logic [31:0] rdata_s;
  logic        rd_pend;
  logic [31:0] rd_data;

  typedef struct {
    bit          fetch;
    logic [31:0] data;
    bit          err;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] req_log[$];
  logic        prev_req;
  logic [31:0] exp_drdata;
  int          errors = 0;
  int          checks = 0;

  assign gnt_s    = auto_mem ? auto_gnt    : man_gnt;
  assign rvalid_s = auto_mem ? auto_rvalid : man_rvalid;
  assign rdata_s  = auto_mem ? auto_rdata  : man_rdata;

  mem_port_arbiter #(.STARVE_MAX(4), .TIMEOUT(64)) dut (
    .clk(clk), .rst_n(rst_n),
    .IReqF(IReqF), .IAddrF(IAddrF), .IRdataF(IRdataF), .IValidF(IValidF),
    .DReqM(DReqM), .DWeM(DWeM), .DAddrM(DAddrM), .DWdataM(DWdataM),
    .DByteEnM(DByteEnM), .DRdataM(DRdataM), .DValidM(DValidM),
    .StallF(StallF), .StallM(StallM),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_gnt(gnt_s),
    .mem_rvalid(rvalid_s), .mem_rdata(rdata_s), .BusErr(BusErr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] memfn(input logic [31:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction

  // Zero-wait memory: grant in the first REQ cycle, read data one cycle later
  always @(negedge clk) begin
    auto_rvalid = rd_pend;
    auto_rdata  = rd_pend ? rd_data : 32'h0;
    auto_gnt    = mem_req;
    if (rd_pend) begin
      rd_pend = 1'b0;
    end else if (mem_req && !mem_we) begin
      rd_pend = 1'b1;
      rd_data = memfn(mem_addr);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic expect_txn(input bit f, input logic [31:0] d, input bit e);
    exp_t x;
    x.fetch = f;
    x.data  = d;
    x.err   = e;
    sb.push_back(x);
  endtask

  task automatic mon();
    exp_t x;
    if (IValidF || DValidM) begin
      chk("no_coincide", {31'b0, IValidF & DValidM}, 32'h0);
      if (sb.size() == 0) begin
        chk("sb_underflow", 32'(sb.size()), 32'd1);
      end else begin
        x = sb.pop_front();
        chk("owner_fetch", {31'b0, IValidF}, {31'b0, x.fetch});
        chk("rdata", IValidF ? IRdataF : DRdataM, x.data);
        chk("buserr", {31'b0, BusErr}, {31'b0, x.err});
      end
    end
    if (mem_req && !prev_req) req_log.push_back(mem_addr);
    prev_req = mem_req;
  endtask

  task automatic step();
    @(negedge clk);
    mon();
  endtask

  task automatic wait_done(input int n, input int budget);
    int seen = 0;
    int cyc  = 0;
    while (seen < n && cyc < budget) begin
      step();
      cyc++;
      if (IValidF || DValidM) seen++;
    end
    chk("wait_done", 32'(seen), 32'(n));
  endtask

  initial begin
    bit early;
    rst_n = 1'b0; IReqF = 1'b0; DReqM = 1'b0; DWeM = 1'b0;
    IAddrF = 32'h0; DAddrM = 32'h0; DWdataM = 32'h0; DByteEnM = 4'h0;
    auto_mem = 1'b0; man_gnt = 1'b0; man_rvalid = 1'b0; man_rdata = 32'h0;
    rd_pend = 1'b0; rd_data = 32'h0; prev_req = 1'b0; exp_drdata = 32'h0;

    // reset values
    step(); step();
    IReqF = 1'b1; DReqM = 1'b1;
    #1;
    chk("rst_stallf", {31'b0, StallF}, 32'h0);
    chk("rst_stallm", {31'b0, StallM}, 32'h0);
    chk("rst_mem_req", {31'b0, mem_req}, 32'h0);
    chk("rst_mem_we", {31'b0, mem_we}, 32'h0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    chk("rst_mem_be", {28'b0, mem_be}, 32'h0);
    chk("rst_valids", {29'b0, IValidF, DValidM, BusErr}, 32'h0);
    chk("rst_irdata", IRdataF, 32'h0);
    chk("rst_drdata", DRdataM, 32'h0);
    IReqF = 1'b0; DReqM = 1'b0;
    step();
    rst_n = 1'b1;
    step();

    // single fetch, immediate grant
    IReqF = 1'b1; IAddrF = 32'h100;
    expect_txn(1'b1, 32'h00500093, 1'b0);
    #1 chk("f_stall_c0", {31'b0, StallF}, 32'h1);
    step();
    chk("f_req", {31'b0, mem_req}, 32'h1);
    chk("f_addr", mem_addr, 32'h100);
    chk("f_be", {28'b0, mem_be}, 32'hF);
    chk("f_we", {31'b0, mem_we}, 32'h0);
    man_gnt = 1'b1;
    step();
    man_gnt = 1'b0;
    chk("f_wait_noreq", {31'b0, mem_req}, 32'h0);
    chk("f_stall_c2", {31'b0, StallF}, 32'h1);
    man_rvalid = 1'b1; man_rdata = 32'h00500093;
    step();
    man_rvalid = 1'b0;
    chk("f_valid_c3", {31'b0, IValidF}, 32'h1);
    chk("f_stall_c3", {31'b0, StallF}, 32'h0);
    IReqF = 1'b0;
    step();
    chk("f_valid_pulse", {31'b0, IValidF}, 32'h0);
    chk("f_rdata_hold", IRdataF, 32'h00500093);

    // store with grant delayed three cycles, rvalid noise ignored
    DReqM = 1'b1; DWeM = 1'b1; DAddrM = 32'h2004; DWdataM = 32'hDEADBEEF; DByteEnM = 4'b0011;
    expect_txn(1'b0, exp_drdata, 1'b0);
    step();
    for (int i = 0; i < 4; i++) begin
      chk("s_req", {31'b0, mem_req}, 32'h1);
      chk("s_we", {31'b0, mem_we}, 32'h1);
      chk("s_addr", mem_addr, 32'h2004);
      chk("s_wdata", mem_wdata, 32'hDEADBEEF);
      chk("s_be", {28'b0, mem_be}, 32'h3);
      chk("s_no_valid", {31'b0, DValidM}, 32'h0);
      man_rvalid = ~man_rvalid;
      DWdataM = (i == 1) ? 32'h12345678 : 32'hDEADBEEF;
      man_gnt = (i == 3);
      step();
    end
    man_gnt = 1'b0; man_rvalid = 1'b0;
    chk("s_valid", {31'b0, DValidM}, 32'h1);
    chk("s_resp_noreq", {31'b0, mem_req}, 32'h0);
    DReqM = 1'b0; DWeM = 1'b0;
    step();
    chk("s_valid_pulse", {31'b0, DValidM}, 32'h0);

    // contention: D,D,D,D,F repeating
    auto_mem = 1'b1;
    IReqF = 1'b1; IAddrF = 32'h200; DReqM = 1'b1; DAddrM = 32'h300;
    for (int k = 0; k < 10; k++) begin
      if (k % 5 == 4) expect_txn(1'b1, memfn(32'h200), 1'b0);
      else            expect_txn(1'b0, memfn(32'h300), 1'b0);
    end
    exp_drdata = memfn(32'h300);
    wait_done(10, 200);
    IReqF = 1'b0; DReqM = 1'b0;
    step();
    chk("c_sb_empty", 32'(sb.size()), 32'd0);

    // load timeout with a fetch waiting behind it
    auto_mem = 1'b0;
    DReqM = 1'b1; DAddrM = 32'h40; IReqF = 1'b1; IAddrF = 32'h500;
    expect_txn(1'b0, 32'h0, 1'b1);
    expect_txn(1'b1, memfn(32'h500), 1'b0);
    exp_drdata = 32'h0;
    step();
    chk("t_addr", mem_addr, 32'h40);
    man_gnt = 1'b1;
    step();
    man_gnt = 1'b0;
    early = 1'b0;
    for (int i = 0; i < 64; i++) begin
      if (DValidM || IValidF) early = 1'b1;
      step();
    end
    chk("t_no_early", {31'b0, early}, 32'h0);
    chk("t_valid_64", {31'b0, DValidM}, 32'h1);
    chk("t_buserr", {31'b0, BusErr}, 32'h1);
    chk("t_drdata_zero", DRdataM, 32'h0);
    chk("t_stallf", {31'b0, StallF}, 32'h1);
    DReqM = 1'b0; auto_mem = 1'b1;
    wait_done(1, 20);
    chk("t_fetch_noerr", {31'b0, BusErr}, 32'h0);
    IReqF = 1'b0;
    step();

    // reset during WAIT, late rvalid during and after reset
    auto_mem = 1'b0;
    DReqM = 1'b1; DAddrM = 32'h80;
    step();
    man_gnt = 1'b1;
    step();
    man_gnt = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("r_irdata", IRdataF, 32'h0);
    chk("r_mem_req", {31'b0, mem_req}, 32'h0);
    chk("r_mem_addr", mem_addr, 32'h0);
    chk("r_mem_be", {28'b0, mem_be}, 32'h0);
    chk("r_stallm", {31'b0, StallM}, 32'h0);
    exp_drdata = 32'h0;
    step();
    man_rvalid = 1'b1; man_rdata = 32'hBAD0BAD0; DReqM = 1'b0;
    step();
    man_rvalid = 1'b0;
    step();
    rst_n = 1'b1; man_rvalid = 1'b1;
    step();
    man_rvalid = 1'b0;
    early = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (DValidM || IValidF || mem_req) early = 1'b1;
      step();
    end
    chk("r_quiet", {31'b0, early}, 32'h0);
    chk("r_drdata", DRdataM, 32'h0);
    DReqM = 1'b1; DAddrM = 32'h84; auto_mem = 1'b1;
    expect_txn(1'b0, memfn(32'h84), 1'b0);
    wait_done(1, 20);
    DReqM = 1'b0;
    step();

    // back-to-back loads, address changed at end of RESP
    req_log.delete();
    DReqM = 1'b1; DAddrM = 32'h10;
    expect_txn(1'b0, memfn(32'h10), 1'b0);
    wait_done(1, 20);
    DAddrM = 32'h14;
    expect_txn(1'b0, memfn(32'h14), 1'b0);
    wait_done(1, 20);
    DReqM = 1'b0;
    step(); step();
    chk("b_req_count", 32'(req_log.size()), 32'd2);
    if (req_log.size() == 2) begin
      chk("b_addr0", req_log[0], 32'h10);
      chk("b_addr1", req_log[1], 32'h14);
    end
    chk("end_sb_empty", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port unified instruction/data memory between the fetch stage (F) and the load/store path in the memory stage (M) of the pipelined core.
- Runs one transaction at a time through a req/gnt/rvalid memory handshake with variable latency.
- Returns read data and completion pulses to each requester, and drives StallF/StallM to the hazard unit.
- Data requests have fixed priority, with a bounded-starvation guarantee for fetch.

Parameters:
- STARVE_MAX, 4, max consecutive data grants while IReqF pending before fetch is forced to win (1..15)
- TIMEOUT, 64, max cycles in WAIT before the transaction is aborted with BusErr (2..255)

Ports:
- clk  in  1  core clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- IReqF  in  1  fetch read request, level, held with IAddrF stable until IValidF
- IAddrF  in  32  fetch address
- IRdataF  out  32  fetch read data, valid with IValidF
- IValidF  out  1  one-cycle fetch completion pulse
- DReqM  in  1  data request, level, fields held stable until DValidM
- DWeM  in  1  1=store, 0=load
- DAddrM  in  32  data address
- DWdataM  in  32  store data
- DByteEnM  in  4  byte enables from LSU decode
- DRdataM  out  32  load data, valid with DValidM
- DValidM  out  1  one-cycle data completion pulse
- StallF  out  1  IReqF & ~IValidF
- StallM  out  1  DReqM & ~DValidM
- mem_req  out  1  memory request
- mem_we  out  1  memory write enable
- mem_addr  out  32  memory address
- mem_wdata  out  32  memory write data
- mem_be  out  4  memory byte enables (4'hF for fetch)
- mem_gnt  in  1  memory accepts request this cycle
- mem_rvalid  in  1  read data valid
- mem_rdata  in  32  read data
- BusErr  out  1  pulses with IValidF/DValidM when the transaction timed out

Behaviour:
- Reset: state IDLE. IValidF, DValidM, BusErr, mem_req, mem_we are 0. mem_addr, mem_wdata, IRdataF, DRdataM are 0. mem_be is 0. Starve counter and timeout counter are 0.
- FSM states: IDLE, REQ, WAIT, RESP.
- IDLE: if any request is pending, arbitrate. Latch owner, addr, we, wdata, be into registers and go to REQ.
  - Winner is data, unless starve counter == STARVE_MAX and IReqF=1, in which case fetch wins.
  - Fetch latches we=0, be=4'hF.
- REQ: mem_req=1 and the memory outputs equal the latched registers.
  - On mem_gnt, a write goes to RESP and a read goes to WAIT.
  - Requests are held indefinitely without gnt; no timeout applies in REQ.
- WAIT: mem_req=0. On mem_rvalid, capture mem_rdata into the owner's Rdata register and go to RESP.
  - Timeout counter increments every cycle in WAIT. At count == TIMEOUT-1 without rvalid: Rdata=32'h0, set BusErr for the RESP cycle, go to RESP.
- RESP: the owner's Valid=1 for exactly this cycle, then go to IDLE. The Rdata register holds its value until the next capture.
  - Requesters drop or change their request at the clock edge that ends RESP. IDLE therefore never re-grants a completed request.
- Minimum latency, with gnt in the first REQ cycle:
  - Read: rvalid the next cycle, then Valid at cycle 3 after IDLE sampling. 4 cycles per transaction.
  - Write: Valid at cycle 2. 3 cycles per transaction.
- Starve counter:
  - Increments (saturating at STARVE_MAX) when data wins in IDLE while IReqF=1.
  - Clears when fetch wins, or when IReqF=0 in IDLE.
- Simultaneous IReqF and DReqM in IDLE: exactly one is granted and the other stays stalled. No request is ever dropped.
- mem_rvalid outside WAIT and mem_gnt outside REQ are ignored.
- Requester-side changes in fields while not in IDLE are ignored, because all transaction fields are latched.
- Reset asserted mid-transaction: immediate return to reset values; the abandoned memory transaction is never completed. A late rvalid after reset is ignored.
- StallF and StallM are combinational from the inputs and registered Valids. Both are 0 during reset.

Test Plan:
- Single fetch: IReqF=1, IAddrF=32'h100, gnt immediate, rvalid+rdata=32'h00500093 one cycle later -> mem_addr=32'h100 with mem_be=4'hF in REQ; IValidF pulses 1 cycle with IRdataF=32'h00500093 at cycle 3; StallF=1 until that cycle.
- Store: DReqM=1, DWeM=1, DAddrM=32'h2004, DWdataM=32'hDEADBEEF, DByteEnM=4'b0011, gnt delayed 3 cycles -> mem_req held 4 cycles with stable fields; DValidM pulses the cycle after gnt; mem_rvalid toggling during the transaction is ignored.
- Contention and starvation (STARVE_MAX=4): IReqF and DReqM both held continuously -> grant order D,D,D,D,F,D,D,D,D,F...; no IValidF/DValidM ever coincide.
- Timeout (TIMEOUT=64): load granted, rvalid never asserted -> DValidM and BusErr pulse together 64 cycles after entering WAIT, DRdataM=0, FSM back in IDLE and serves a pending fetch normally.
- Reset mid-read: rst_n low while in WAIT, rvalid arrives during reset and just after release -> all outputs return to 0 asynchronously; no Valid pulse after release; the next request completes with correct data.
- Back-to-back loads to 32'h10 then 32'h14 with requester changing address at the end of RESP -> two distinct mem_req transactions, no duplicate grant of 32'h10.
